// File: rtl/conv11_input_sched_if.sv
// Handshake/configuration bundle for the conv11 input scheduler.
// The stall_cycles signal exists only when CONV11_INPUT_SCHED_PERF_EN is defined.
interface conv11_input_sched_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 8,
    parameter int CH_WIDTH   = 8
) ();
    logic                  start;
    logic                  abort;
    logic [DIM_WIDTH-1:0]  cfg_width;
    logic [DIM_WIDTH-1:0]  cfg_height;
    logic [CH_WIDTH-1:0]   cfg_cin;
    logic [CH_WIDTH-1:0]   cfg_cout;
    logic                  input_ready;
    logic                  compute_ready;
    logic                  fm_rd_en;
    logic [ADDR_WIDTH-1:0] fm_rd_addr;
    logic [ADDR_WIDTH-1:0] wt_rd_addr;
    logic                  input_valid;
    logic                  inputbuf_read_en;
    logic                  acc_first;
    logic                  acc_last;
    logic                  busy;
    logic                  done;
`ifdef CONV11_INPUT_SCHED_PERF_EN
    logic [31:0]           stall_cycles;
`endif

    modport master (
        output start, abort, cfg_width, cfg_height, cfg_cin, cfg_cout,
        output input_ready, compute_ready,
        input  fm_rd_en, fm_rd_addr, wt_rd_addr, input_valid,
        input  inputbuf_read_en, acc_first, acc_last, busy, done
`ifdef CONV11_INPUT_SCHED_PERF_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  start, abort, cfg_width, cfg_height, cfg_cin, cfg_cout,
        input  input_ready, compute_ready,
        output fm_rd_en, fm_rd_addr, wt_rd_addr, input_valid,
        output inputbuf_read_en, acc_first, acc_last, busy, done
`ifdef CONV11_INPUT_SCHED_PERF_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/conv11_input_sched.sv
// 1x1-convolution input sequencer: one element in flight, ISSUE -> LOAD -> CONSUME per element.
// Define CONV11_INPUT_SCHED_PERF_EN to add the stall_cycles performance counter.
module conv11_input_sched #(
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 8,
    parameter int CH_WIDTH   = 8
) (
    input logic                 clk,
    input logic                 rst,
    conv11_input_sched_if.slave sif
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_LOAD    = 3'd2,
        S_CONSUME = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [DIM_WIDTH-1:0]  width_q,     width_d;
    logic [DIM_WIDTH-1:0]  height_q,    height_d;
    logic [CH_WIDTH-1:0]   cin_q,       cin_d;
    logic [CH_WIDTH-1:0]   cout_q,      cout_d;
    logic [DIM_WIDTH-1:0]  col_q,       col_d;
    logic [DIM_WIDTH-1:0]  row_q,       row_d;
    logic [CH_WIDTH-1:0]   ci_q,        ci_d;
    logic [CH_WIDTH-1:0]   co_q,        co_d;
    logic [ADDR_WIDTH-1:0] fm_addr_q,   fm_addr_d;
    logic [ADDR_WIDTH-1:0] wt_addr_q,   wt_addr_d;
    logic [ADDR_WIDTH-1:0] wt_base_q,   wt_base_d;
    logic                  fm_rd_en_q,  fm_rd_en_d;
    logic                  in_valid_q,  in_valid_d;
    logic                  rd_en_q,     rd_en_d;
    logic                  acc_first_q, acc_first_d;
    logic                  acc_last_q,  acc_last_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic                  last_ci_s;
    logic                  last_col_s;
    logic                  last_row_s;
    logic                  last_co_s;
    logic                  cfg_zero_s;
    logic                  both_ready_s;
    logic [ADDR_WIDTH-1:0] cin_ext_s;

    assign last_ci_s    = (ci_q  == (cin_q    - CH_WIDTH'(1)));
    assign last_col_s   = (col_q == (width_q  - DIM_WIDTH'(1)));
    assign last_row_s   = (row_q == (height_q - DIM_WIDTH'(1)));
    assign last_co_s    = (co_q  == (cout_q   - CH_WIDTH'(1)));
    assign cfg_zero_s   = (sif.cfg_width  == DIM_WIDTH'(0)) || (sif.cfg_height == DIM_WIDTH'(0)) ||
                          (sif.cfg_cin    == CH_WIDTH'(0))  || (sif.cfg_cout   == CH_WIDTH'(0));
    assign both_ready_s = sif.input_ready && sif.compute_ready;
    assign cin_ext_s    = ADDR_WIDTH'(cin_q);

    // Next-state, counter and strobe computation; strobes default low so each lasts one cycle.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        cin_d       = cin_q;
        cout_d      = cout_q;
        col_d       = col_q;
        row_d       = row_q;
        ci_d        = ci_q;
        co_d        = co_q;
        fm_addr_d   = fm_addr_q;
        wt_addr_d   = wt_addr_q;
        wt_base_d   = wt_base_q;
        fm_rd_en_d  = 1'b0;
        in_valid_d  = 1'b0;
        rd_en_d     = 1'b0;
        acc_first_d = 1'b0;
        acc_last_d  = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sif.start) begin
                    width_d   = sif.cfg_width;
                    height_d  = sif.cfg_height;
                    cin_d     = sif.cfg_cin;
                    cout_d    = sif.cfg_cout;
                    col_d     = DIM_WIDTH'(0);
                    row_d     = DIM_WIDTH'(0);
                    ci_d      = CH_WIDTH'(0);
                    co_d      = CH_WIDTH'(0);
                    fm_addr_d = ADDR_WIDTH'(0);
                    wt_addr_d = ADDR_WIDTH'(0);
                    wt_base_d = ADDR_WIDTH'(0);
                    state_d   = cfg_zero_s ? S_DONE : S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (both_ready_s) begin
                    fm_rd_en_d = 1'b1;
                    state_d    = S_LOAD;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_LOAD: begin
                in_valid_d = 1'b1;
                state_d    = S_CONSUME;
            end
            S_CONSUME: begin
                rd_en_d     = 1'b1;
                acc_first_d = (ci_q == CH_WIDTH'(0));
                acc_last_d  = last_ci_s;
                // Loop nest, innermost first: ci, col, row, co. Weight address rewinds per pixel.
                if (!last_ci_s) begin
                    ci_d      = ci_q + CH_WIDTH'(1);
                    fm_addr_d = fm_addr_q + ADDR_WIDTH'(1);
                    wt_addr_d = wt_addr_q + ADDR_WIDTH'(1);
                    state_d   = S_ISSUE;
                end else if (!last_col_s) begin
                    ci_d      = CH_WIDTH'(0);
                    col_d     = col_q + DIM_WIDTH'(1);
                    fm_addr_d = fm_addr_q + ADDR_WIDTH'(1);
                    wt_addr_d = wt_base_q;
                    state_d   = S_ISSUE;
                end else if (!last_row_s) begin
                    ci_d      = CH_WIDTH'(0);
                    col_d     = DIM_WIDTH'(0);
                    row_d     = row_q + DIM_WIDTH'(1);
                    fm_addr_d = fm_addr_q + ADDR_WIDTH'(1);
                    wt_addr_d = wt_base_q;
                    state_d   = S_ISSUE;
                end else if (!last_co_s) begin
                    ci_d      = CH_WIDTH'(0);
                    col_d     = DIM_WIDTH'(0);
                    row_d     = DIM_WIDTH'(0);
                    co_d      = co_q + CH_WIDTH'(1);
                    fm_addr_d = ADDR_WIDTH'(0);
                    wt_base_d = wt_base_q + cin_ext_s;
                    wt_addr_d = wt_base_q + cin_ext_s;
                    state_d   = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition and suppresses any strobe or done pulse.
        if (sif.abort) begin
            state_d     = S_IDLE;
            fm_rd_en_d  = 1'b0;
            in_valid_d  = 1'b0;
            rd_en_d     = 1'b0;
            acc_first_d = 1'b0;
            acc_last_d  = 1'b0;
            done_d      = 1'b0;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != S_IDLE);
    end

`ifdef CONV11_INPUT_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Stall counter: cleared by an accepted start, saturating, counts unready ISSUE cycles.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && sif.start) begin
            stall_d = 32'd0;
        end else if ((state_q == S_ISSUE) && !both_ready_s && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    assign sif.stall_cycles = stall_q;
`endif

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            width_q     <= DIM_WIDTH'(0);
            height_q    <= DIM_WIDTH'(0);
            cin_q       <= CH_WIDTH'(0);
            cout_q      <= CH_WIDTH'(0);
            col_q       <= DIM_WIDTH'(0);
            row_q       <= DIM_WIDTH'(0);
            ci_q        <= CH_WIDTH'(0);
            co_q        <= CH_WIDTH'(0);
            fm_addr_q   <= ADDR_WIDTH'(0);
            wt_addr_q   <= ADDR_WIDTH'(0);
            wt_base_q   <= ADDR_WIDTH'(0);
            fm_rd_en_q  <= 1'b0;
            in_valid_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CONV11_INPUT_SCHED_PERF_EN
            stall_q     <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            cin_q       <= cin_d;
            cout_q      <= cout_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ci_q        <= ci_d;
            co_q        <= co_d;
            fm_addr_q   <= fm_addr_d;
            wt_addr_q   <= wt_addr_d;
            wt_base_q   <= wt_base_d;
            fm_rd_en_q  <= fm_rd_en_d;
            in_valid_q  <= in_valid_d;
            rd_en_q     <= rd_en_d;
            acc_first_q <= acc_first_d;
            acc_last_q  <= acc_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef CONV11_INPUT_SCHED_PERF_EN
            stall_q     <= stall_d;
`endif
        end
    end

    assign sif.fm_rd_en         = fm_rd_en_q;
    assign sif.fm_rd_addr       = fm_addr_q;
    assign sif.wt_rd_addr       = wt_addr_q;
    assign sif.input_valid      = in_valid_q;
    assign sif.inputbuf_read_en = rd_en_q;
    assign sif.acc_first        = acc_first_q;
    assign sif.acc_last         = acc_last_q;
    assign sif.busy             = busy_q;
    assign sif.done             = done_q;
endmodule

// File: doc/conv11_input_sched.md
Name: conv11_input_sched

Overview:
- Sequencer for the 1x1-convolution input path.
- Walks a feature map of cfg_height x cfg_width pixels with cfg_cin input channels, once per output channel (cfg_cout passes).
- Issues feature/weight RAM reads, drives input_valid into the conv11 input buffer, then inputbuf_read_en toward the MAC.
- Tags each element with accumulate-first/last flags and signals layer completion.

Parameters:
- ADDR_WIDTH, 16: width of fm_rd_addr and wt_rd_addr.
- DIM_WIDTH, 8: width of cfg_width/cfg_height and row/col counters.
- CH_WIDTH, 8: width of cfg_cin/cfg_cout and channel counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; latches cfg_* and begins a layer (IDLE only)
- abort  in  1  synchronous cancel; return to IDLE next cycle
- cfg_width  in  DIM_WIDTH  pixels per row
- cfg_height  in  DIM_WIDTH  rows
- cfg_cin  in  CH_WIDTH  input channels
- cfg_cout  in  CH_WIDTH  output channels
- input_ready  in  1  input path can accept a new element
- compute_ready  in  1  MAC can consume an element
- fm_rd_en  out  1  feature RAM read strobe (RAM latency 1 cycle)
- fm_rd_addr  out  ADDR_WIDTH  feature address = pixel*cin + ci
- wt_rd_addr  out  ADDR_WIDTH  weight address = co*cin + ci
- input_valid  out  1  RAM data valid at input buffer
- inputbuf_read_en  out  1  present buffered element to MAC
- acc_first  out  1  with inputbuf_read_en: ci==0
- acc_last  out  1  with inputbuf_read_en: ci==cin-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at layer completion

Behaviour:
- All outputs registered. Reset: all outputs 0, addresses 0, counters 0, state IDLE.
- States:
  - IDLE: on start, latch cfg, clear counters. Any cfg field zero -> DONE, else -> ISSUE. start ignored outside IDLE.
  - ISSUE: wait until input_ready && compute_ready. Then fm_rd_en=1 for 1 cycle with current addresses -> LOAD.
  - LOAD: input_valid=1 for 1 cycle -> CONSUME.
  - CONSUME: inputbuf_read_en=1 for 1 cycle, acc_first/acc_last per ci. Advance counters. Last element -> DONE, else -> ISSUE.
  - DONE: done=1 for 1 cycle -> IDLE.
- Element timing: exactly one element in flight; 3 cycles per element when never stalled. Strobes (fm_rd_en, input_valid, inputbuf_read_en) are never high simultaneously.
- Loop order, innermost first: ci, then pixel (col, then row), then co.
  - fm_rd_addr increments by 1 per element and resets to 0 when co advances.
  - wt_rd_addr = co*cin + ci, maintained incrementally (no multiplier): rewinds to co*cin at each new pixel, advances by cin at each new co.
- Last element: ci=cin-1, col=width-1, row=height-1, co=cout-1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no overflow flag.
- abort has priority over every transition. Next cycle: IDLE, all strobes 0, no done pulse.
- Reset mid-operation: immediate return to reset values.
- input_ready/compute_ready are sampled only in ISSUE; deassertion in LOAD/CONSUME does not stall.

Optional Feature:
- Macro: CONV11_INPUT_SCHED_PERF_EN.
- When defined:
  - Adds output stall_cycles [31:0]: counts cycles spent in ISSUE with input_ready && compute_ready false.
  - Cleared on start, saturates at 0xFFFFFFFF, holds after DONE, reset value 0.
- When undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset/idle: assert rst mid-ISSUE -> all outputs 0 within same cycle; busy=0; no done.
- Minimal layer: width=1, height=1, cin=1, cout=1, readies held 1.
  - fm_rd_en at cycle 1 after start, input_valid at 2, inputbuf_read_en with acc_first=acc_last=1 at 3, done at 4.
- Address order: width=2, height=1, cin=3, cout=2, readies 1.
  - fm_rd_addr sequence 0..5,0..5.
  - wt_rd_addr 0,1,2,0,1,2,3,4,5,3,4,5.
  - acc_first on every ci=0, acc_last on every ci=2.
  - 12 inputbuf_read_en pulses, then done.
- Backpressure: hold input_ready=0 for 5 cycles in ISSUE -> no fm_rd_en during stall, addresses stable. With PERF_EN, stall_cycles=5.
- Zero config: start with cin=0 -> done 1 cycle after leaving IDLE, no fm_rd_en ever.
- Abort/start-while-busy: start pulse during LOAD ignored. abort in CONSUME -> IDLE next cycle, no done. Next start restarts at address 0.
